// File: rtl/spi_dma_pkg.sv
// Shared types and helpers for the DMA read arbiter slice.
package spi_dma_pkg;

    // Default configuration of the arbiter.
    localparam int NC_DEF = 2;
    localparam int AW_DEF = 32;
    localparam int BL_DEF = 4;
    localparam int DW_DEF = 32;
    localparam int OW_DEF = 2;

    // Bus issue state machine.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // ceil(log2(n)), never less than 1 so a 1-channel index still has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    localparam int CW_DEF = clog2_min1(NC_DEF);

    // One outstanding burst as recorded in the order FIFO (default widths).
    typedef struct packed {
        logic [CW_DEF-1:0] ch;
        logic [BL_DEF:0]   len;
    } ord_entry_t;

endpackage

// File: rtl/spi_dma_rd_arb_if.sv
// Channel-side request/response bundle plus the Avalon-MM burst read master.
interface spi_dma_rd_arb_if #(
    parameter int NC = 2,
    parameter int AW = 32,
    parameter int BL = 4,
    parameter int DW = 32,
    parameter int OW = 2
);
    logic [NC-1:0]        ch_req;
    logic [NC*AW-1:0]     ch_adr;
    logic [NC*(BL+1)-1:0] ch_len;
    logic [NC-1:0]        ch_ack;
    logic [NC-1:0]        ch_rsp_val;
    logic [DW-1:0]        rsp_data;
    logic [AW-1:0]        avm_address;
    logic [BL:0]          avm_burstcount;
    logic                 avm_read;
    logic                 avm_waitrequest;
    logic [DW-1:0]        avm_readdata;
    logic                 avm_readdatavalid;
    logic [OW:0]          outstanding;
    logic                 err;

    // Arbiter side.
    modport master (
        input  ch_req, ch_adr, ch_len,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output ch_ack, ch_rsp_val, rsp_data,
        output avm_address, avm_burstcount, avm_read,
        output outstanding, err
    );

    // Channels plus bus slave side.
    modport slave (
        output ch_req, ch_adr, ch_len,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  ch_ack, ch_rsp_val, rsp_data,
        input  avm_address, avm_burstcount, avm_read,
        input  outstanding, err
    );
endinterface

// File: rtl/spi_dma_ord_fifo.sv
// Order FIFO: remembers (channel, length) of every accepted burst in issue order.
module spi_dma_ord_fifo #(
    parameter int W  = 6,
    parameter int OW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [OW:0]   count_o
);
    localparam int DEPTH = 1 << OW;
    localparam logic [OW:0] DEPTH_C = (OW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [OW-1:0] wr_ptr_q;
    logic [OW-1:0] rd_ptr_q;
    logic [OW:0]   count_q;
    logic [OW:0]   count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == {(OW+1){1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Occupancy next-state; a push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (OW+1)'(1);
            2'b01:   count_d = count_q - (OW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {OW{1'b0}};
            rd_ptr_q <= {OW{1'b0}};
            count_q  <= {(OW+1){1'b0}};
        end else begin
            count_q <= count_d;
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + OW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + OW'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/spi_dma_rd_arb.sv
// Round-robin sharing of one Avalon-MM burst read master between DMA read channels.
module spi_dma_rd_arb
    import spi_dma_pkg::*;
#(
    parameter int NC = NC_DEF,
    parameter int CW = clog2_min1(NC),
    parameter int AW = AW_DEF,
    parameter int BL = BL_DEF,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input logic             clk,
    input logic             rst_n,
    spi_dma_rd_arb_if.master bus
);
    localparam logic [BL:0] LEN_MAX = {1'b1, {BL{1'b0}}};
    localparam int          EW      = CW + BL + 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  ptr_q;
    logic [CW-1:0]  grant_q;
    logic [AW-1:0]  adr_q;
    logic [BL:0]    len_q;
    logic           avm_read_q;
    logic [NC-1:0]  elig_s;
    logic           found_s;
    logic [CW-1:0]  win_s;
    logic           latch_s;
    logic           accept_s;
    logic [NC-1:0]  ack_s;

    logic [EW-1:0]  fifo_rdata_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [OW:0]    fifo_count_s;
    logic [CW-1:0]  head_ch_s;
    logic [BL:0]    head_len_s;
    logic           pop_s;
    logic [BL:0]    cnt_q;
    logic [NC-1:0]  rsp_val_d;
    logic [NC-1:0]  rsp_val_q;
    logic [DW-1:0]  rsp_data_q;
    logic           err_q;

    // A channel competes only with a length the bus can carry (1..2**BL).
    always_comb begin
        elig_s = {NC{1'b0}};
        for (int i = 0; i < NC; i++) begin
            if (bus.ch_req[i] &&
                (bus.ch_len[i*(BL+1) +: BL+1] != {(BL+1){1'b0}}) &&
                (bus.ch_len[i*(BL+1) +: BL+1] <= LEN_MAX)) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
    end

    // Round-robin winner: first eligible index after the last grant, wrapping.
    always_comb begin
        int idx;
        found_s = 1'b0;
        win_s   = {CW{1'b0}};
        idx     = 0;
        for (int k = 1; k <= NC; k++) begin
            idx = (int'(ptr_q) + k) % NC;
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                win_s   = CW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign accept_s = avm_read_q & ~bus.avm_waitrequest;

    // Issue FSM next state; a full order FIFO holds off new grants.
    always_comb begin
        state_d = state_q;
        latch_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s && !fifo_full_s) begin
                    state_d = ST_ISSUE;
                    latch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue FSM state, latched command and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= CW'(NC - 1);
            grant_q    <= {CW{1'b0}};
            adr_q      <= {AW{1'b0}};
            len_q      <= {(BL+1){1'b0}};
            avm_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            avm_read_q <= (state_d == ST_ISSUE);
            if (latch_s) begin
                grant_q <= win_s;
                adr_q   <= bus.ch_adr[int'(win_s)*AW +: AW];
                len_q   <= bus.ch_len[int'(win_s)*(BL+1) +: BL+1];
            end
            if (accept_s) begin
                ptr_q <= grant_q;
            end
        end
    end

    // Acknowledge pulse to the owner in the cycle the bus takes the command.
    always_comb begin
        ack_s = {NC{1'b0}};
        if (accept_s) begin
            ack_s[grant_q] = 1'b1;
        end else begin
            ack_s = {NC{1'b0}};
        end
    end

    spi_dma_ord_fifo #(
        .W  (EW),
        .OW (OW)
    ) u_ord_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept_s),
        .wdata_i ({grant_q, len_q}),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign head_ch_s  = fifo_rdata_s[EW-1 -: CW];
    assign head_len_s = fifo_rdata_s[BL:0];

    // Beat routing: owner is the oldest outstanding burst; its last beat pops it.
    always_comb begin
        rsp_val_d = {NC{1'b0}};
        pop_s     = 1'b0;
        if (bus.avm_readdatavalid && !fifo_empty_s) begin
            rsp_val_d[head_ch_s] = 1'b1;
            pop_s = ((cnt_q + (BL+1)'(1)) == head_len_s);
        end else begin
            rsp_val_d = {NC{1'b0}};
            pop_s     = 1'b0;
        end
    end

    // Registered response path, beat counter and sticky orphan-beat flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {(BL+1){1'b0}};
            rsp_val_q  <= {NC{1'b0}};
            rsp_data_q <= {DW{1'b0}};
            err_q      <= 1'b0;
        end else begin
            rsp_val_q <= rsp_val_d;
            if (bus.avm_readdatavalid) begin
                rsp_data_q <= bus.avm_readdata;
                if (fifo_empty_s) begin
                    err_q <= 1'b1;
                end else if (pop_s) begin
                    cnt_q <= {(BL+1){1'b0}};
                end else begin
                    cnt_q <= cnt_q + (BL+1)'(1);
                end
            end
        end
    end

    assign bus.ch_ack         = ack_s;
    assign bus.ch_rsp_val     = rsp_val_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.avm_address    = adr_q;
    assign bus.avm_burstcount = len_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.outstanding    = fifo_count_s;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_spi_dma_rd_arb.sv
// Directed bench for spi_dma_rd_arb: NC=2, AW=32, BL=4, DW=32, OW=2.
module tb_spi_dma_rd_arb;
    localparam int NC = 2;
    localparam int AW = 32;
    localparam int BL = 4;
    localparam int DW = 32;
    localparam int OW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_dma_rd_arb_if #(.NC(NC), .AW(AW), .BL(BL), .DW(DW), .OW(OW)) bus ();

    spi_dma_rd_arb #(.NC(NC), .AW(AW), .BL(BL), .DW(DW), .OW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] adr, input logic [4:0] len);
        bus.ch_adr[i*AW +: AW]         = adr;
        bus.ch_len[i*(BL+1) +: BL+1]   = len;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_read"}, 64'(bus.avm_read), 64'd0);
        check_val({tag, "_addr"}, 64'(bus.avm_address), 64'd0);
        check_val({tag, "_bc"}, 64'(bus.avm_burstcount), 64'd0);
        check_val({tag, "_ack"}, 64'(bus.ch_ack), 64'd0);
        check_val({tag, "_rspval"}, 64'(bus.ch_rsp_val), 64'd0);
        check_val({tag, "_rspdata"}, 64'(bus.rsp_data), 64'd0);
        check_val({tag, "_err"}, 64'(bus.err), 64'd0);
        check_val({tag, "_outst"}, 64'(bus.outstanding), 64'd0);
    endtask

    initial begin
        logic [1:0] own8 [8];
        logic [1:0] ack_exp;
        own8 = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};

        bus.ch_req = '0;
        bus.ch_adr = '0;
        bus.ch_len = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = '0;
        bus.avm_readdatavalid = 1'b0;

        // Reset state
        step();
        step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // Single channel burst, len 4
        set_ch(0, 32'h0000_1000, 5'd4);
        bus.ch_req = 2'b01;
        step();
        check_val("s_read", 64'(bus.avm_read), 64'd1);
        check_val("s_addr", 64'(bus.avm_address), 64'h1000);
        check_val("s_bc", 64'(bus.avm_burstcount), 64'd4);
        check_val("s_ack", 64'(bus.ch_ack), 64'h1);
        bus.ch_req = 2'b00;
        step();
        check_val("s_read_drop", 64'(bus.avm_read), 64'd0);
        check_val("s_ack_drop", 64'(bus.ch_ack), 64'd0);
        check_val("s_outst1", 64'(bus.outstanding), 64'd1);
        for (int i = 0; i < 4; i++) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = 32'hA0 + 32'(i);
            step();
            check_val("s_rspval", 64'(bus.ch_rsp_val), 64'h1);
            check_val("s_rspdata", 64'(bus.rsp_data), 64'(32'hA0 + 32'(i)));
        end
        bus.avm_readdatavalid = 1'b0;
        check_val("s_outst0", 64'(bus.outstanding), 64'd0);
        step();
        check_val("s_rspval_end", 64'(bus.ch_rsp_val), 64'd0);

        // Reset again so channel 0 wins first, then alternate grants
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_ch(0, 32'h0000_2000, 5'd2);
        set_ch(1, 32'h0000_3000, 5'd2);
        bus.ch_req = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            ack_exp = (k % 2 == 1) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check_val("f_ack", 64'(bus.ch_ack), 64'(ack_exp));
            check_val("f_read", 64'(bus.avm_read), 64'(k % 2));
            if (k % 2 == 1) begin
                check_val("f_addr", 64'(bus.avm_address),
                          (ack_exp == 2'b01) ? 64'h2000 : 64'h3000);
            end
        end
        check_val("f_outst4", 64'(bus.outstanding), 64'd4);

        // Order FIFO full: channel 0 waits until the first burst pops
        set_ch(0, 32'h0000_4000, 5'd2);
        bus.ch_req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("full_read", 64'(bus.avm_read), 64'd0);
            check_val("full_outst", 64'(bus.outstanding), 64'd4);
        end
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = 32'hC0;
        step();
        check_val("full_b0_val", 64'(bus.ch_rsp_val), 64'h1);
        check_val("full_b0_outst", 64'(bus.outstanding), 64'd4);
        bus.avm_readdata = 32'hC1;
        step();
        check_val("full_b1_val", 64'(bus.ch_rsp_val), 64'h1);
        check_val("full_b1_outst", 64'(bus.outstanding), 64'd3);
        check_val("full_b1_read", 64'(bus.avm_read), 64'd0);
        bus.avm_readdatavalid = 1'b0;
        step();
        check_val("full_grant_read", 64'(bus.avm_read), 64'd1);
        check_val("full_grant_addr", 64'(bus.avm_address), 64'h4000);
        check_val("full_grant_ack", 64'(bus.ch_ack), 64'h1);
        bus.ch_req = 2'b00;
        step();
        check_val("full_outst_back", 64'(bus.outstanding), 64'd4);
        for (int i = 0; i < 8; i++) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = 32'hD0 + 32'(i);
            step();
            check_val("drain_owner", 64'(bus.ch_rsp_val), 64'(own8[i]));
        end
        bus.avm_readdatavalid = 1'b0;
        step();
        check_val("drain_outst", 64'(bus.outstanding), 64'd0);

        // Waitrequest held 5 cycles on a ch1 command
        set_ch(1, 32'h0000_5000, 5'd3);
        bus.ch_req = 2'b10;
        bus.avm_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("w_read", 64'(bus.avm_read), 64'd1);
            check_val("w_addr", 64'(bus.avm_address), 64'h5000);
            check_val("w_bc", 64'(bus.avm_burstcount), 64'd3);
            check_val("w_ack", 64'(bus.ch_ack), 64'd0);
        end
        bus.avm_waitrequest = 1'b0;
        #1;
        check_val("w_ack_accept", 64'(bus.ch_ack), 64'h2);
        bus.ch_req = 2'b00;
        step();
        check_val("w_read_after", 64'(bus.avm_read), 64'd0);
        check_val("w_outst", 64'(bus.outstanding), 64'd1);
        step();
        check_val("w_no_second", 64'(bus.avm_read), 64'd0);
        for (int i = 0; i < 3; i++) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = 32'hE0 + 32'(i);
            step();
            check_val("w_rspval", 64'(bus.ch_rsp_val), 64'h2);
        end
        bus.avm_readdatavalid = 1'b0;
        step();
        check_val("w_outst0", 64'(bus.outstanding), 64'd0);

        // Interleaved ownership; last ch0 beat pops while ch1 is pushed
        set_ch(0, 32'h0000_6000, 5'd3);
        set_ch(1, 32'h0000_7000, 5'd1);
        bus.ch_req = 2'b11;
        step();
        check_val("i_ack0", 64'(bus.ch_ack), 64'h1);
        bus.ch_req = 2'b10;
        step();
        check_val("i_outst1", 64'(bus.outstanding), 64'd1);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = 32'hB0;
        step();
        check_val("i_b0_val", 64'(bus.ch_rsp_val), 64'h1);
        check_val("i_b0_data", 64'(bus.rsp_data), 64'hB0);
        check_val("i_ch1_addr", 64'(bus.avm_address), 64'h7000);
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata = 32'hB1;
        #1;
        check_val("i_ack_held", 64'(bus.ch_ack), 64'd0);
        step();
        check_val("i_b1_val", 64'(bus.ch_rsp_val), 64'h1);
        check_val("i_b1_outst", 64'(bus.outstanding), 64'd1);
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'hB2;
        #1;
        check_val("i_ack1", 64'(bus.ch_ack), 64'h2);
        step();
        check_val("i_b2_val", 64'(bus.ch_rsp_val), 64'h1);
        check_val("i_pushpop_outst", 64'(bus.outstanding), 64'd1);
        bus.ch_req = 2'b00;
        bus.avm_readdata = 32'hB3;
        step();
        check_val("i_b3_val", 64'(bus.ch_rsp_val), 64'h2);
        check_val("i_b3_data", 64'(bus.rsp_data), 64'hB3);
        check_val("i_outst0", 64'(bus.outstanding), 64'd0);
        bus.avm_readdatavalid = 1'b0;
        step();

        // Orphan beat sets the sticky error
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata = 32'hEE;
        step();
        check_val("e_err", 64'(bus.err), 64'd1);
        check_val("e_rspval", 64'(bus.ch_rsp_val), 64'd0);
        check_val("e_outst", 64'(bus.outstanding), 64'd0);
        bus.avm_readdatavalid = 1'b0;
        step();
        step();
        check_val("e_sticky", 64'(bus.err), 64'd1);

        // Illegal lengths 0 and 17 are never granted
        set_ch(0, 32'h0000_8000, 5'd0);
        set_ch(1, 32'h0000_9000, 5'd17);
        bus.ch_req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("bad_len_read", 64'(bus.avm_read), 64'd0);
            check_val("bad_len_ack", 64'(bus.ch_ack), 64'd0);
        end

        // Max length 16 accepted, then async reset mid-ISSUE
        bus.ch_req = 2'b01;
        set_ch(0, 32'h0000_A000, 5'd16);
        bus.avm_waitrequest = 1'b1;
        step();
        check_val("m_read", 64'(bus.avm_read), 64'd1);
        check_val("m_bc16", 64'(bus.avm_burstcount), 64'd16);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        bus.ch_req = 2'b00;
        bus.avm_waitrequest = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_val("post_rst_read", 64'(bus.avm_read), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

endmodule

// File: doc/spi_dma_rd_arb.md
Name: spi_dma_rd_arb

Overview:
- Round-robin arbiter and scheduler sharing one Avalon-MM burst read master between NC DMA read channels.
- Each channel presents a burst request (address and word count) on a biu-style interface.
- The block issues one burst at a time on the bus and records (channel, length) per accepted burst in an order FIFO.
- It routes each readdatavalid beat back to the channel that owns the oldest outstanding burst.

Parameters:
- NC, 2, number of requesting channels (2..8)
- CW, 1, channel index width, ceil(log2(NC)), min 1
- AW, 32, byte address width
- BL, 4, max burst exponent; burst length field is BL+1 bits (1..2**BL)
- DW, 32, read data width
- OW, 2, order FIFO depth exponent (2**OW outstanding bursts max)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ch_req  in  NC  per-channel burst request
- ch_adr  in  NC*AW  per-channel byte address, channel i at [i*AW +: AW]
- ch_len  in  NC*(BL+1)  per-channel burst length in words
- ch_ack  out  NC  one-cycle pulse: channel's burst accepted by bus
- ch_rsp_val  out  NC  one-hot read beat strobe to owning channel
- rsp_data  out  DW  read data, broadcast to all channels
- avm_address  out  AW  bus address
- avm_burstcount  out  BL+1  bus burst length
- avm_read  out  1  bus read command
- avm_waitrequest  in  1  bus stall
- avm_readdata  in  DW  bus read data
- avm_readdatavalid  in  1  bus read beat valid
- outstanding  out  OW+1  order FIFO occupancy
- err  out  1  sticky: beat received with no outstanding burst

Behaviour:
- Reset values:
  - avm_read=0, avm_address=0, avm_burstcount=0, ch_ack=0, ch_rsp_val=0, rsp_data=0, err=0, outstanding=0.
  - Round-robin pointer = NC-1, so channel 0 wins first.
  - Order FIFO empty, beat counter 0, FSM = IDLE.
- Eligible channel: ch_req[i]=1 and ch_len[i] in 1..2**BL. A request with len 0 or len >2**BL is ignored, never acked.
- FSM IDLE:
  - Move to ISSUE if any channel is eligible and the order FIFO is not full.
  - Winner = first eligible channel after the last granted index, wrapping modulo NC.
  - Latch the winner's ch_adr, ch_len and index into registers. avm_read=1 from the next cycle.
- FSM ISSUE:
  - avm_read, avm_address and avm_burstcount are registered and held stable while avm_waitrequest=1.
  - On avm_read & ~avm_waitrequest:
    - ch_ack[grant]=1 for exactly that cycle.
    - Push {grant, len} to the order FIFO.
    - Pointer <= grant.
    - Next state IDLE, with avm_read=0 the following cycle.
  - Max issue rate is one burst every 2 cycles. The mandatory IDLE bubble lets the channel update its length/address before it is re-arbitrated.
- Channel contract: ch_adr/ch_len of a requesting channel stay stable until its ch_ack. ch_req is not withdrawn before ack; if it is withdrawn, the latched burst is still issued and acked.
- Response path:
  - rsp_data and ch_rsp_val are registered: 1 cycle latency from avm_readdatavalid.
  - ch_rsp_val = onehot(FIFO head channel) when avm_readdatavalid.
  - Beat counter increments per beat. When counter+1 == head len: pop the FIFO and clear the counter.
- Simultaneous push and pop in one cycle: occupancy unchanged. Both operations take effect.
- Full: FIFO holds 2**OW entries. IDLE does not start a new grant, and already-issued commands are unaffected. Full is checked at grant, and only one command is in flight in ISSUE, so no overflow is possible.
- avm_readdatavalid with the FIFO empty:
  - err<=1 (sticky until reset).
  - No ch_rsp_val is asserted. Counter and FIFO are unchanged.
- The response path is independent of the FSM: beats are accepted in every state.
- Reset mid-burst: all state is cleared immediately. The system resets the bus and the channels together.

Decomposition:
- Shared package spi_dma_pkg:
  - FSM state enum (IDLE, ISSUE).
  - Function for ceil-log2.
  - Order-entry typedef {ch[CW-1:0], len[BL:0]}.
- One sub-module: spi_dma_ord_fifo. Synchronous FIFO, depth 2**OW, width CW+BL+1, with push/pop/full/empty/count and same-cycle push+pop support.
- Round-robin select stays inline in the top.

Test Plan:
- Single channel: ch0 req, adr 0x1000, len 4, waitrequest 0 → avm_read one cycle with addr 0x1000 and burstcount 4; ch_ack[0] in the same cycle. 4 beats → ch_rsp_val[0] ×4, 1 cycle delayed; outstanding returns to 0.
- Fairness: ch0 and ch1 requesting continuously, len 2 each → grants alternate 0,1,0,1, with a 1-cycle idle between commands.
- Waitrequest: hold waitrequest for 5 cycles → address and burstcount stable, ch_ack only in the acceptance cycle, no second command.
- FIFO full (OW=2): issue 4 bursts with no responses → a 5th request is not granted until the first burst's last beat pops the FIFO; the grant follows within 2 cycles.
- Interleaved ownership: ch0 len 3 then ch1 len 1 accepted → beats 1-3 go to ch_rsp_val[0] and beat 4 to ch_rsp_val[1]. Verify the pop on the last beat coincides with a new push.
- Error: avm_readdatavalid with no outstanding burst → err=1 stays set, no ch_rsp_val. Async reset mid-ISSUE → all outputs return to reset values in the same cycle.
